// File: rtl/gray_burst_arbiter.sv
// gray_burst_arbiter
//   One global Gray-code sequence generator shared between NREQ requesters.
//   A round-robin arbiter grants one burst at a time. A burst of L+1
//   consecutive codes is streamed on a valid/ready interface and tagged with
//   the owner's index. The underlying binary counter continues across bursts
//   and owners. It restarts only on reset.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req        in   [NREQ]        per-requester burst request
//   req_len    in   [NREQ*LEN_W]  burst length per requester (L gives L+1 codes)
//   out_ready  in   downstream accepts the current code
//   gnt        out  [NREQ]  one-hot owner of the burst in progress
//   out_valid  out  out_gray/out_id carry a code
//   out_gray   out  [WIDTH] current Gray code
//   out_id     out  [ID_W]  owner index
//   done       out  [NREQ]  one-cycle pulse after the owner's last code transfers
//   busy       out  high while a burst is running
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no burst; arbitrate on any request (includes the done cycle)
// RUN   | streaming a burst; advance on out_ready
module gray_burst_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic                    out_ready,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_gray,
    output logic [ID_W-1:0]         out_id,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] bin;
    logic [LEN_W-1:0] rem;
    logic [ID_W-1:0]  ptr;

    logic [ID_W-1:0]  win;
    logic             found;
    logic [ID_W:0]    idx_ext;
    logic [ID_W:0]    nxt_ext;
    logic [ID_W-1:0]  ptr_next;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Round-robin search starting at ptr. The index is kept one bit wider so
    // the wrap works for NREQ that is not a power of two.
    always_comb begin
        win     = ptr;
        found   = 1'b0;
        idx_ext = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_ext = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx_ext >= (ID_W+1)'(NREQ))
                idx_ext = idx_ext - (ID_W+1)'(NREQ);
            if (!found && req[idx_ext[ID_W-1:0]]) begin
                win   = idx_ext[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    // The next round-robin start is the slot after the current owner.
    always_comb begin
        nxt_ext = {1'b0, out_id} + (ID_W+1)'(1);
        if (nxt_ext >= (ID_W+1)'(NREQ))
            nxt_ext = '0;
        ptr_next = nxt_ext[ID_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bin       <= '0;
            rem       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_id    <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        out_id    <= win;
                        out_valid <= 1'b1;
                        out_gray  <= to_gray(bin);
                        bin       <= bin + 1'b1;
                        rem       <= req_len[int'(win)*LEN_W +: LEN_W];
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (rem != '0) begin
                            out_gray <= to_gray(bin);
                            bin      <= bin + 1'b1;
                            rem      <= rem - 1'b1;
                        end else begin
                            // out_gray keeps the last code. out_valid is low.
                            out_valid    <= 1'b0;
                            gnt          <= '0;
                            busy         <= 1'b0;
                            done[out_id] <= 1'b1;
                            ptr          <= ptr_next;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
